// File: rtl/pc_seq_pkg.sv
// Shared codes for the PC sequencer and programCounter.
// Opcodes, PS/BC encodings, ALU functions and FSM states.
package pc_seq_pkg;

  localparam logic [1:0] PS_HOLD = 2'd0;
  localparam logic [1:0] PS_INC  = 2'd1;
  localparam logic [1:0] PS_REL  = 2'd2;
  localparam logic [1:0] PS_ABS  = 2'd3;

  localparam logic [1:0] BC_ZERO   = 2'd0;
  localparam logic [1:0] BC_NZERO  = 2'd1;
  localparam logic [1:0] BC_ALWAYS = 2'd3;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_AND  = 4'h3;
  localparam logic [3:0] OP_OR   = 4'h4;
  localparam logic [3:0] OP_MOV  = 4'h5;
  localparam logic [3:0] OP_LD   = 4'h6;
  localparam logic [3:0] OP_ST   = 4'h7;
  localparam logic [3:0] OP_BZ   = 4'h8;
  localparam logic [3:0] OP_BNZ  = 4'h9;
  localparam logic [3:0] OP_BRA  = 4'hA;
  localparam logic [3:0] OP_JR   = 4'hB;
  localparam logic [3:0] OP_HALT = 4'hF;

  localparam logic [2:0] FS_PASS = 3'd0;
  localparam logic [2:0] FS_ADD  = 3'd1;
  localparam logic [2:0] FS_SUB  = 3'd2;
  localparam logic [2:0] FS_AND  = 3'd3;
  localparam logic [2:0] FS_OR   = 3'd4;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_HALT
  } state_t;

  function automatic logic is_alu_op(
    input logic [3:0] op
  );
    return (op >= OP_ADD) && (op <= OP_OR);
  endfunction

endpackage

// File: rtl/pc_seq_decode.sv
// Combinational opcode classifier for the PC sequencer.
// Reports ALU function, writeback, memory, branch and illegal classes.
module pc_seq_decode
  import pc_seq_pkg::*;
(
  input  logic [3:0] opcode,
  output logic [2:0] alu_fs,
  output logic       rf_we,
  output logic       is_mem,
  output logic       is_branch,
  output logic       illegal
);

  always_comb begin
    alu_fs    = FS_PASS;
    rf_we     = 1'b0;
    is_mem    = 1'b0;
    is_branch = 1'b0;
    illegal   = 1'b0;
    unique case (1'b1)
      is_alu_op(opcode): begin
        alu_fs = opcode[2:0];
        rf_we  = 1'b1;
      end
      opcode == OP_MOV: rf_we = 1'b1;
      opcode == OP_LD: begin
        rf_we  = 1'b1;
        is_mem = 1'b1;
      end
      opcode == OP_ST: is_mem = 1'b1;
      (opcode >= OP_BZ) && (opcode <= OP_JR):
        is_branch = 1'b1;
      (opcode > OP_JR) && (opcode < OP_HALT):
        illegal = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/pc_sequencer.sv
// Multi-cycle fetch/decode/execute sequencer driving the PC and datapath.
// PC_SEQ_PERF_EN adds retired/stall counters.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int INSTR_W      = 16,
  parameter int REG_AW       = 4,
  parameter int IMEM_TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [INSTR_W-1:0] instr,
  input  logic              instr_valid,
  output logic              instr_req,
  input  logic              dmem_ready,
  output logic [1:0]        BC,
  output logic [1:0]        PS,
  output logic [REG_AW-1:0] AA,
  output logic [REG_AW-1:0] BA,
  output logic [REG_AW-1:0] DA,
  output logic              rf_we,
  output logic [2:0]        alu_fs,
  output logic              dmem_re,
  output logic              dmem_we,
  output logic              halted,
  output logic              fault
`ifdef PC_SEQ_PERF_EN
  ,
  output logic [15:0]       retired_cnt,
  output logic [15:0]       stall_cnt
`endif
);

  localparam int CW = $clog2(IMEM_TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST =
    CW'(IMEM_TIMEOUT - 1);

  state_t state, next;
  logic [INSTR_W-1:0] ir;
  logic [CW-1:0] cnt;
  logic fault_q;

  logic ir_load, cnt_inc, cnt_clr, set_fault;
  logic [3:0] op;
  logic [2:0] dec_fs;
  logic dec_rf_we, dec_mem, dec_br, dec_ill;

  assign op = ir[INSTR_W-1 -: 4];
  assign DA = ir[3*REG_AW-1 -: REG_AW];
  assign AA = ir[2*REG_AW-1 -: REG_AW];
  assign BA = ir[REG_AW-1:0];
  assign halted = (state == S_HALT);
  assign fault  = fault_q;

  pc_seq_decode u_dec (
    .opcode    (op),
    .alu_fs    (dec_fs),
    .rf_we     (dec_rf_we),
    .is_mem    (dec_mem),
    .is_branch (dec_br),
    .illegal   (dec_ill)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_FETCH;
      ir      <= '0;
      cnt     <= '0;
      fault_q <= 1'b0;
    end else begin
      state <= next;
      if (ir_load)
        ir <= instr;
      if (cnt_clr)
        cnt <= '0;
      else if (cnt_inc)
        cnt <= cnt + 1'b1;
      if (set_fault)
        fault_q <= 1'b1;
    end
  end

  // PC is parked with BC=ALWAYS/PS=HOLD unless a state says otherwise
  always_comb begin
    next      = state;
    instr_req = 1'b0;
    BC        = BC_ALWAYS;
    PS        = PS_HOLD;
    rf_we     = 1'b0;
    alu_fs    = FS_PASS;
    dmem_re   = 1'b0;
    dmem_we   = 1'b0;
    ir_load   = 1'b0;
    cnt_inc   = 1'b0;
    cnt_clr   = 1'b0;
    set_fault = 1'b0;
    unique case (state)
      S_FETCH: begin
        instr_req = 1'b1;
        if (instr_valid) begin
          ir_load = 1'b1;
          cnt_clr = 1'b1;
          next    = S_DECODE;
        end else if (cnt == CNT_LAST) begin
          set_fault = 1'b1;
          next      = S_HALT;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      S_DECODE: begin
        if (dec_ill) begin
          set_fault = 1'b1;
          next      = S_HALT;
        end else begin
          next = S_EXEC;
        end
      end
      S_EXEC: begin
        alu_fs = dec_fs;
        next   = S_FETCH;
        unique case (1'b1)
          dec_mem: begin
            dmem_re = (op == OP_LD);
            dmem_we = (op == OP_ST);
            next    = S_MEM;
          end
          dec_br: begin
            PS = (op == OP_JR) ? PS_ABS : PS_REL;
            if (op == OP_BZ)
              BC = BC_ZERO;
            else if (op == OP_BNZ)
              BC = BC_NZERO;
          end
          (op == OP_HALT) || dec_ill:
            next = S_HALT;
          default: begin
            rf_we = dec_rf_we;
            PS    = PS_INC;
          end
        endcase
      end
      S_MEM: begin
        dmem_re = (op == OP_LD);
        dmem_we = (op == OP_ST);
        if (dmem_ready) begin
          rf_we = (op == OP_LD);
          PS    = PS_INC;
          next  = S_FETCH;
        end
      end
      S_HALT: ;
      default: next = S_FETCH;
    endcase
  end

`ifdef PC_SEQ_PERF_EN
  logic stall;
  assign stall =
    ((state == S_FETCH) && !instr_valid) ||
    ((state == S_MEM) && !dmem_ready);

  always_ff @(posedge clk) begin
    if (reset) begin
      retired_cnt <= '0;
      stall_cnt   <= '0;
    end else begin
      if (PS != PS_HOLD && retired_cnt != 16'hFFFF)
        retired_cnt <= retired_cnt + 16'd1;
      if (stall && stall_cnt != 16'hFFFF)
        stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif

endmodule
